// File: rtl/contador_regressivo_mmss.sv
// contador_regressivo_mmss: BCD MM:SS countdown timer with an internal
// one-second prescaler, ripple borrow and a completion flag at 00:00.
`default_nettype none

module contador_regressivo_mmss #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] preset_min_d,
  input  logic [3:0] preset_min_u,
  input  logic [3:0] preset_sec_d,
  input  logic [3:0] preset_sec_u,
  output logic [3:0] min_d,
  output logic [3:0] min_u,
  output logic [3:0] sec_d,
  output logic [3:0] sec_u,
  output logic       borrow,
  output logic       running,
  output logic       done
);

  localparam int             PW        = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]  LAST_TICK = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [3:0]    min_d_nxt, min_u_nxt, sec_d_nxt, sec_u_nxt;
  logic          borrow_nxt;
  logic          is_zero, is_one;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign is_zero = ({min_d, min_u, sec_d, sec_u} == 16'h0000);
  assign is_one  = ({min_d, min_u, sec_d, sec_u} == 16'h0001);

  always_comb begin
    state_nxt  = state;
    presc_nxt  = presc;
    min_d_nxt  = min_d;
    min_u_nxt  = min_u;
    sec_d_nxt  = sec_d;
    sec_u_nxt  = sec_u;
    borrow_nxt = 1'b0;

    if (load) begin
      min_d_nxt = clamp(preset_min_d, 4'd5);
      min_u_nxt = clamp(preset_min_u, 4'd9);
      sec_d_nxt = clamp(preset_sec_d, 4'd5);
      sec_u_nxt = clamp(preset_sec_u, 4'd9);
      presc_nxt = '0;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !pause) begin
            if (is_zero) begin
              state_nxt = DONE;
            end else begin
              state_nxt = RUNNING;
              presc_nxt = '0;
            end
          end
        end

        RUNNING: begin
          if (pause) begin
            state_nxt = PAUSED;
          end else if (presc == LAST_TICK) begin
            presc_nxt = '0;
            // Reaching 00:00 ends the count; never wrap around to 59:59.
            if (is_one || is_zero) begin
              min_d_nxt = 4'd0;
              min_u_nxt = 4'd0;
              sec_d_nxt = 4'd0;
              sec_u_nxt = 4'd0;
              state_nxt = DONE;
            end else if (sec_u != 4'd0) begin
              sec_u_nxt = sec_u - 4'd1;
            end else begin
              sec_u_nxt  = 4'd9;
              borrow_nxt = 1'b1;
              if (sec_d != 4'd0) begin
                sec_d_nxt = sec_d - 4'd1;
              end else begin
                sec_d_nxt = 4'd5;
                if (min_u != 4'd0) begin
                  min_u_nxt = min_u - 4'd1;
                end else begin
                  min_u_nxt = 4'd9;
                  min_d_nxt = min_d - 4'd1;
                end
              end
            end
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end

        PAUSED: begin
          if (start && !pause) begin
            state_nxt = RUNNING;
          end
        end

        DONE: begin
          state_nxt = DONE;
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      presc   <= '0;
      min_d   <= 4'd0;
      min_u   <= 4'd0;
      sec_d   <= 4'd0;
      sec_u   <= 4'd0;
      borrow  <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      presc   <= presc_nxt;
      min_d   <= min_d_nxt;
      min_u   <= min_u_nxt;
      sec_d   <= sec_d_nxt;
      sec_u   <= sec_u_nxt;
      borrow  <= borrow_nxt;
      running <= (state_nxt == RUNNING);
      done    <= (state_nxt == DONE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_contador_regressivo_mmss.sv
// ============================================================================
// Module      : tb_contador_regressivo_mmss
// Description : Scoreboard bench for contador_regressivo_mmss, TICKS_PER_SEC=4
// Revision    : 1.1
// ============================================================================
`default_nettype none

module tb_contador_regressivo_mmss;

    logic       r_clk = 1'b0;
    logic       r_rst, r_load, r_start, r_pause;
    logic [3:0] r_preset_min_d, r_preset_min_u, r_preset_sec_d, r_preset_sec_u;
    logic [3:0] w_min_d, w_min_u, w_sec_d, w_sec_u;
    logic       w_borrow, w_running, w_done;
    logic [15:0] w_val;

    assign w_val = {w_min_d, w_min_u, w_sec_d, w_sec_u};

    contador_regressivo_mmss #(.TICKS_PER_SEC(4)) dut (
        .clk(r_clk), .reset(r_rst), .load(r_load), .start(r_start), .pause(r_pause),
        .preset_min_d(r_preset_min_d), .preset_min_u(r_preset_min_u),
        .preset_sec_d(r_preset_sec_d), .preset_sec_u(r_preset_sec_u),
        .min_d(w_min_d), .min_u(w_min_u), .sec_d(w_sec_d), .sec_u(w_sec_u),
        .borrow(w_borrow), .running(w_running), .done(w_done)
    );

    always #5 r_clk = ~r_clk;

    typedef struct packed {
        int          cyc;
        logic [15:0] val;
        logic        b;
        logic        r;
        logic        dn;
    } exp_t;

    exp_t  r_exp_q[$];
    string r_name_q[$];
    int    r_cyc = 0;
    int    r_total = 0;
    int    r_bad = 0;

    always @(posedge r_clk) r_cyc <= r_cyc + 1;

    always @(negedge r_clk) begin
        while (r_exp_q.size() > 0 && r_exp_q[0].cyc <= r_cyc) begin
            exp_t        e;
            string       nm;
            logic [15:0] got;
            e   = r_exp_q.pop_front();
            nm  = r_name_q.pop_front();
            got = w_val;
            r_total++;
            if (e.cyc != r_cyc || got !== e.val || w_borrow !== e.b || w_running !== e.r || w_done !== e.dn) begin
                r_bad++;
                $display("FAIL %s @cyc%0d: got %h b=%b r=%b d=%b, want %h b=%b r=%b d=%b (cyc%0d)",
                         nm, r_cyc, got, w_borrow, w_running, w_done, e.val, e.b, e.r, e.dn, e.cyc);
            end
        end
    end

    task automatic want(input string nm, input int d, input logic [15:0] v,
                        input logic b, input logic r, input logic dn);
        exp_t e;
        e.cyc = r_cyc + d; e.val = v; e.b = b; e.r = r; e.dn = dn;
        r_exp_q.push_back(e);
        r_name_q.push_back(nm);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge r_clk);
            #1;
        end
    endtask

    task automatic set_preset(input logic [15:0] p);
        {r_preset_min_d, r_preset_min_u, r_preset_sec_d, r_preset_sec_u} = p;
    endtask

    task automatic load_chk(input string nm, input logic [15:0] p, input logic [15:0] e);
        set_preset(p);
        r_load = 1'b1;
        want(nm, 1, e, 1'b0, 1'b0, 1'b0);
        step(1);
        r_load = 1'b0;
    endtask

    task automatic start_chk(input string nm, input logic [15:0] e, input logic r, input logic dn);
        r_start = 1'b1;
        want(nm, 1, e, 1'b0, r, dn);
        step(1);
        r_start = 1'b0;
    endtask

    initial begin
        r_rst   = 1'b1;
        r_load  = 1'($urandom); r_start = 1'($urandom); r_pause = 1'($urandom);
        set_preset(16'($urandom));
        want("rst_a", 1, 16'h0000, 1'b0, 1'b0, 1'b0);
        want("rst_b", 2, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1);
        r_load  = 1'($urandom); r_start = 1'($urandom); r_pause = 1'($urandom);
        set_preset(16'($urandom));
        step(1);
        r_total++;
        if (w_val !== 16'h0000 || w_borrow !== 1'b0 || w_running !== 1'b0 || w_done !== 1'b0) begin
            r_bad++;
            $display("FAIL d_rst: got %h b=%b r=%b d=%b", w_val, w_borrow, w_running, w_done);
        end
        r_rst = 1'b0; r_load = 1'b0; r_start = 1'b0; r_pause = 1'b0;

        load_chk("t2_load", 16'h0100, 16'h0100);
        start_chk("t2_run", 16'h0100, 1'b1, 1'b0);
        want("t2_pre",    3, 16'h0100, 1'b0, 1'b1, 1'b0);
        want("t2_dec1",   4, 16'h0059, 1'b1, 1'b1, 1'b0);
        want("t2_bpulse", 5, 16'h0059, 1'b0, 1'b1, 1'b0);
        want("t2_dec2",   8, 16'h0058, 1'b0, 1'b1, 1'b0);
        step(8);
        r_total++;
        if (w_val !== 16'h0058 || w_borrow !== 1'b0 || w_running !== 1'b1 || w_done !== 1'b0) begin
            r_bad++;
            $display("FAIL d_t2: got %h b=%b r=%b d=%b", w_val, w_borrow, w_running, w_done);
        end

        load_chk("t3_load", 16'h0002, 16'h0002);
        start_chk("t3_run", 16'h0002, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++)
            want("t3_cnt", k, (k < 4) ? 16'h0002 : (k < 8) ? 16'h0001 : 16'h0000,
                 1'b0, (k < 8), (k == 8));
        step(8);
        r_total++;
        if (w_val !== 16'h0000 || w_borrow !== 1'b0 || w_running !== 1'b0 || w_done !== 1'b1) begin
            r_bad++;
            $display("FAIL d_t3: got %h b=%b r=%b d=%b", w_val, w_borrow, w_running, w_done);
        end
        r_start = 1'b1;
        want("t3_ign_a", 1, 16'h0000, 1'b0, 1'b0, 1'b1);
        want("t3_ign_b", 2, 16'h0000, 1'b0, 1'b0, 1'b1);
        step(2);
        r_start = 1'b0;

        load_chk("t4_load", 16'h0010, 16'h0010);
        start_chk("t4_run", 16'h0010, 1'b1, 1'b0);
        step(2);
        r_pause = 1'b1;
        for (int k = 1; k <= 5; k++)
            want("t4_hold", k, 16'h0010, 1'b0, 1'b0, 1'b0);
        step(5);
        r_pause = 1'b0;
        r_start = 1'b1;
        want("t4_res1", 1, 16'h0010, 1'b0, 1'b1, 1'b0);
        want("t4_res2", 2, 16'h0010, 1'b0, 1'b1, 1'b0);
        want("t4_dec",  3, 16'h0009, 1'b1, 1'b1, 1'b0);
        want("t4_post", 4, 16'h0009, 1'b0, 1'b1, 1'b0);
        step(1);
        r_start = 1'b0;
        step(3);

        load_chk("t5_clamp", 16'h7C9F, 16'h5959);
        load_chk("t5_clamp2", 16'h63A4, 16'h5354);
        load_chk("t5_zero", 16'h0000, 16'h0000);
        start_chk("t5_done", 16'h0000, 1'b0, 1'b1);
        r_total++;
        if (w_val !== 16'h0000 || w_running !== 1'b0 || w_done !== 1'b1) begin
            r_bad++;
            $display("FAIL d_t5: got %h r=%b d=%b", w_val, w_running, w_done);
        end
        load_chk("t5_reld", 16'h0005, 16'h0005);
        r_start = 1'b1; r_pause = 1'b1;
        want("t5_stpa", 1, 16'h0005, 1'b0, 1'b0, 1'b0);
        step(1);
        r_start = 1'b0; r_pause = 1'b0;

        load_chk("t6_load", 16'h0045, 16'h0045);
        start_chk("t6_run", 16'h0045, 1'b1, 1'b0);
        step(3);
        want("t6_pre", 0, 16'h0045, 1'b0, 1'b1, 1'b0);
        set_preset(16'h0330);
        r_load = 1'b1;
        want("t6_reload", 1, 16'h0330, 1'b0, 1'b0, 1'b0);
        step(1);
        r_load = 1'b0;
        start_chk("t6_run2", 16'h0330, 1'b1, 1'b0);
        step(2);
        r_rst = 1'b1; r_start = 1'b1;
        want("t6_rst", 1, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1);
        r_total++;
        if (w_val !== 16'h0000 || w_borrow !== 1'b0 || w_running !== 1'b0 || w_done !== 1'b0) begin
            r_bad++;
            $display("FAIL d_t6rst: got %h b=%b r=%b d=%b", w_val, w_borrow, w_running, w_done);
        end
        r_rst = 1'b0;
        set_preset(16'h0007);
        r_load = 1'b1; r_start = 1'b1;
        want("t6_ldwin", 1, 16'h0007, 1'b0, 1'b0, 1'b0);
        step(1);
        r_load = 1'b0; r_start = 1'b0;
        want("t6_idle", 1, 16'h0007, 1'b0, 1'b0, 1'b0);
        step(1);
        r_total++;
        if (w_val !== 16'h0007 || w_running !== 1'b0 || w_done !== 1'b0) begin
            r_bad++;
            $display("FAIL d_t6idle: got %h r=%b d=%b", w_val, w_running, w_done);
        end

        for (int i = 0; i < 20 && r_exp_q.size() > 0; i++) @(posedge r_clk);
        while (r_exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = r_exp_q.pop_front();
            nm = r_name_q.pop_front();
            r_total++;
            r_bad++;
            $display("FAIL %s: never observed, want %h at cyc%0d", nm, e.val, e.cyc);
        end
        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule

`default_nettype wire
